// File: rtl/uparc_muldiv_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide controller: operation
// codes, register widths and controller states.
package uparc_muldiv_ctrl_pkg;

  localparam int unsigned REG_WIDTH  = 32;
  localparam int unsigned HILO_WIDTH = REG_WIDTH;

  typedef enum logic [2:0] {
    OP_MFHI  = 3'd0,
    OP_MFLO  = 3'd1,
    OP_MTHI  = 3'd2,
    OP_MTLO  = 3'd3,
    OP_MULT  = 3'd4,
    OP_MULTU = 3'd5,
    OP_DIV   = 3'd6,
    OP_DIVU  = 3'd7
  } muldiv_op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MUL_START = 3'd1,
    ST_MUL_WAIT  = 3'd2,
    ST_DIV_START = 3'd3,
    ST_DIV_WAIT  = 3'd4
  } muldiv_state_e;

  function automatic logic op_is_signed(input muldiv_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/uparc_muldiv_ctrl.sv
// HI/LO controller for the execute stage: sequences the external multiplier
// and divider, owns HI/LO and serves MFHI/MFLO/MTHI/MTLO.
module uparc_muldiv_ctrl
  import uparc_muldiv_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    op_valid,
  input  logic [2:0]              op,
  input  logic [REG_WIDTH-1:0]    op_a,
  input  logic [REG_WIDTH-1:0]    op_b,
  input  logic                    flush,
  output logic                    stall,
  output logic                    busy,
  output logic                    rd_valid,
  output logic [REG_WIDTH-1:0]    rd_data,
  output logic                    mul_start,
  output logic                    mul_signd,
  output logic [REG_WIDTH-1:0]    mul_a,
  output logic [REG_WIDTH-1:0]    mul_b,
  input  logic                    mul_ready,
  input  logic [2*REG_WIDTH-1:0]  mul_product,
  output logic                    div_start,
  output logic                    div_signd,
  output logic [REG_WIDTH-1:0]    div_a,
  output logic [REG_WIDTH-1:0]    div_b,
  input  logic                    div_ready,
  input  logic [REG_WIDTH-1:0]    div_quot,
  input  logic [REG_WIDTH-1:0]    div_rem
);

  // Request handshake: a request (op_valid) is taken in the same cycle only
  // when the FSM is IDLE and flush is low; otherwise stall is raised unless
  // flush is discarding the request outright.

  muldiv_state_e             state;
  muldiv_state_e             state_next;
  muldiv_op_e                op_dec;
  logic [HILO_WIDTH-1:0]     hi;
  logic [HILO_WIDTH-1:0]     lo;
  logic [HILO_WIDTH-1:0]     hi_d;
  logic [HILO_WIDTH-1:0]     lo_d;
  logic                      hi_we;
  logic                      lo_we;
  logic [REG_WIDTH-1:0]      opnd_a;
  logic [REG_WIDTH-1:0]      opnd_b;
  logic                      signd;
  logic                      latch_opnd;
  logic                      accept;

  assign op_dec = muldiv_op_e'(op);
  assign accept = op_valid && (state == ST_IDLE) && !flush;

  assign stall    = op_valid && (state != ST_IDLE) && !flush;
  assign rd_valid = accept && ((op_dec == OP_MFHI) || (op_dec == OP_MFLO));
  assign rd_data  = (op_dec == OP_MFHI) ? hi : lo;

  // Units see the operand registers directly; they only change on accept,
  // which keeps them stable for the whole start/wait sequence.
  assign busy      = (state != ST_IDLE);
  assign mul_start = (state == ST_MUL_START);
  assign div_start = (state == ST_DIV_START);
  assign mul_a     = opnd_a;
  assign mul_b     = opnd_b;
  assign mul_signd = signd;
  assign div_a     = opnd_a;
  assign div_b     = opnd_b;
  assign div_signd = signd;

  always_comb begin
    state_next = state;
    latch_opnd = 1'b0;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    hi_d       = hi;
    lo_d       = lo;
    if (flush) begin
      state_next = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (op_valid) begin
            case (op_dec)
              OP_MTHI: begin
                hi_we = 1'b1;
                hi_d  = op_a;
              end
              OP_MTLO: begin
                lo_we = 1'b1;
                lo_d  = op_a;
              end
              OP_MULT, OP_MULTU: begin
                latch_opnd = 1'b1;
                state_next = ST_MUL_START;
              end
              OP_DIV, OP_DIVU: begin
                // Divide by zero is architecturally undefined: leave HI/LO alone.
                if (op_b != '0) begin
                  latch_opnd = 1'b1;
                  state_next = ST_DIV_START;
                end
              end
              default: ;
            endcase
          end
        end
        ST_MUL_START: state_next = ST_MUL_WAIT;
        ST_MUL_WAIT: begin
          if (mul_ready) begin
            hi_we      = 1'b1;
            lo_we      = 1'b1;
            hi_d       = mul_product[2*REG_WIDTH-1:REG_WIDTH];
            lo_d       = mul_product[REG_WIDTH-1:0];
            state_next = ST_IDLE;
          end
        end
        ST_DIV_START: state_next = ST_DIV_WAIT;
        ST_DIV_WAIT: begin
          if (div_ready) begin
            hi_we      = 1'b1;
            lo_we      = 1'b1;
            hi_d       = div_rem;
            lo_d       = div_quot;
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      hi     <= '0;
      lo     <= '0;
      opnd_a <= '0;
      opnd_b <= '0;
      signd  <= 1'b0;
    end else begin
      state <= state_next;
      if (hi_we) hi <= hi_d;
      if (lo_we) lo <= lo_d;
      if (latch_opnd) begin
        opnd_a <= op_a;
        opnd_b <= op_b;
        signd  <= op_is_signed(op_dec);
      end
    end
  end

endmodule

// File: tb/tb_uparc_muldiv_ctrl.sv
// Bench for uparc_muldiv_ctrl: behavioural multiplier/divider units plus a
// HI/LO reference model driven by directed and random operation sequences.
module tb_uparc_muldiv_ctrl;

  localparam logic [2:0] OP_MFHI  = 3'd0;
  localparam logic [2:0] OP_MFLO  = 3'd1;
  localparam logic [2:0] OP_MTHI  = 3'd2;
  localparam logic [2:0] OP_MTLO  = 3'd3;
  localparam logic [2:0] OP_MULT  = 3'd4;
  localparam logic [2:0] OP_MULTU = 3'd5;
  localparam logic [2:0] OP_DIV   = 3'd6;
  localparam logic [2:0] OP_DIVU  = 3'd7;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        mul_start;
  logic        mul_signd;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_ready;
  logic [63:0] mul_product;
  logic        div_start;
  logic        div_signd;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_ready;
  logic [31:0] div_quot;
  logic [31:0] div_rem;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  uparc_muldiv_ctrl dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .op_a(op_a), .op_b(op_b),
    .flush(flush), .stall(stall), .busy(busy), .rd_valid(rd_valid), .rd_data(rd_data),
    .mul_start(mul_start), .mul_signd(mul_signd), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ready(mul_ready), .mul_product(mul_product),
    .div_start(div_start), .div_signd(div_signd), .div_a(div_a), .div_b(div_b),
    .div_ready(div_ready), .div_quot(div_quot), .div_rem(div_rem)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference arithmetic ----------------
  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint pa, pb;
    pa = s ? longint'($signed(a)) : longint'(a);
    pb = s ? longint'($signed(b)) : longint'(b);
    return 64'(pa * pb);
  endfunction

  // Returns {remainder, quotient}, truncating toward zero.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    if (sb == 0) return 64'h0;
    q = sa / sb;
    r = sa % sb;
    return {32'(r), 32'(q)};
  endfunction

  function automatic logic [63:0] unit_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  // ---------------- behavioural units ----------------
  // Ready is low in the start cycle; a zero operand finishes the next cycle,
  // otherwise the result appears 33 cycles after the start cycle.
  int mul_cnt = 0;
  int div_cnt = 0;

  always @(posedge clk) begin
    if (rst) mul_cnt <= 0;
    else if (mul_start) mul_cnt <= (mul_a == 0 || mul_b == 0) ? 0 : 32;
    else if (mul_cnt != 0) mul_cnt <= mul_cnt - 1;
  end

  always @(posedge clk) begin
    if (rst) div_cnt <= 0;
    else if (div_start) div_cnt <= (div_a == 0) ? 0 : 32;
    else if (div_cnt != 0) div_cnt <= div_cnt - 1;
  end

  assign mul_ready   = (mul_cnt == 0) && !mul_start;
  assign div_ready   = (div_cnt == 0) && !div_start;
  assign mul_product = mul_ready ? unit_mul(mul_signd, mul_a, mul_b) : 64'hBAD0_BAD0_BAD0_BAD0;
  assign {div_rem, div_quot} = div_ready ? ref_div(div_signd, div_a, div_b) : 64'hDEAD_DEAD_DEAD_DEAD;

  // ---------------- driver tasks ----------------
  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = v;
    op       = o;
    op_a     = a;
    op_b     = b;
  endtask

  task automatic peek(input logic [2:0] o, output logic [31:0] v, output logic vl);
    go();
    drive(1'b1, o, $urandom, $urandom);
    @(negedge clk);
    v  = rd_data;
    vl = rd_valid;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'($urandom_range(1, 15));
      2:       return 32'h8000_0000 | $urandom;
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation, present `probe` (MFHI or MFLO) every following cycle
  // until it is accepted, then read the other register; all checked against
  // the reference model.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] probe);
    logic [31:0] e_hi, e_lo, exp_rd;
    logic [63:0] r;
    logic        is_mul, is_div, sg;
    int exp_lat, exp_ms, exp_ds, lat, ms, ds, both, stalls, rd_bad, opnd_bad;
    e_hi = m_hi; e_lo = m_lo; exp_lat = 1;
    is_mul = (o == OP_MULT) || (o == OP_MULTU);
    is_div = (o == OP_DIV) || (o == OP_DIVU);
    sg     = (o == OP_MULT) || (o == OP_DIV);
    if (o == OP_MTHI) e_hi = a;
    if (o == OP_MTLO) e_lo = a;
    if (is_mul) begin
      r = ref_mul(sg, a, b);
      e_hi = r[63:32]; e_lo = r[31:0];
      exp_lat = (a == 0 || b == 0) ? 3 : 35;
    end
    if (is_div && b != 0) begin
      r = ref_div(sg, a, b);
      e_hi = r[63:32]; e_lo = r[31:0];
      exp_lat = (a == 0) ? 3 : 35;
    end
    exp_ms = is_mul ? 1 : 0;
    exp_ds = (is_div && b != 0) ? 1 : 0;
    ms = 0; ds = 0; both = 0; stalls = 0; rd_bad = 0; opnd_bad = 0; lat = 0;

    go();
    drive(1'b1, o, a, b);
    @(negedge clk);
    if (mul_start) ms++;
    if (div_start) ds++;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL %s accept_stall: got %b want 0", tag, stall);
    end
    exp_rd = (o == OP_MFHI) ? m_hi : m_lo;
    n_cmp++;
    if (o == OP_MFHI || o == OP_MFLO) begin
      if (rd_valid !== 1'b1 || rd_data !== exp_rd) begin
        n_fail++; $display("FAIL %s mf_read: got v=%b d=%h want v=1 d=%h", tag, rd_valid, rd_data, exp_rd);
      end
    end else if (rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s rd_valid_idle: got %b want 0", tag, rd_valid);
    end

    do begin
      go();
      drive(1'b1, probe, $urandom, $urandom);
      lat++;
      @(negedge clk);
      if (mul_start) ms++;
      if (div_start) ds++;
      if (mul_start && div_start) both++;
      if (busy) begin
        if (stall) stalls++;
        if (rd_valid) rd_bad++;
        if (is_mul && (mul_a !== a || mul_b !== b || mul_signd !== sg)) opnd_bad++;
        if (is_div && (div_a !== a || div_b !== b || div_signd !== sg)) opnd_bad++;
      end
    end while (busy && lat < 80);

    n_cmp++;
    if (lat != exp_lat) begin
      n_fail++; $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
    end
    n_cmp++;
    if (stalls != exp_lat - 1) begin
      n_fail++; $display("FAIL %s stall_cycles: got %0d want %0d", tag, stalls, exp_lat - 1);
    end
    n_cmp++;
    if (ms != exp_ms || ds != exp_ds || both != 0) begin
      n_fail++; $display("FAIL %s start_pulses: got mul=%0d div=%0d both=%0d want mul=%0d div=%0d both=0",
                         tag, ms, ds, both, exp_ms, exp_ds);
    end
    n_cmp++;
    if (opnd_bad != 0 || rd_bad != 0) begin
      n_fail++; $display("FAIL %s busy_outputs: got opnd_bad=%0d rd_bad=%0d want 0 0", tag, opnd_bad, rd_bad);
    end
    exp_rd = (probe == OP_MFHI) ? e_hi : e_lo;
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== exp_rd) begin
      n_fail++; $display("FAIL %s first_read: got v=%b d=%h want v=1 d=%h", tag, rd_valid, rd_data, exp_rd);
    end

    go();
    drive(1'b1, (probe == OP_MFHI) ? OP_MFLO : OP_MFHI, 32'h0, 32'h0);
    @(negedge clk);
    exp_rd = (probe == OP_MFHI) ? e_lo : e_hi;
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== exp_rd) begin
      n_fail++; $display("FAIL %s second_read: got v=%b d=%h want v=1 d=%h", tag, rd_valid, rd_data, exp_rd);
    end
    m_hi = e_hi;
    m_lo = e_lo;
    go();
    drive(1'b0, OP_MFHI, 32'h0, 32'h0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] v;
    logic        vl;
    rst = 1'b1; flush = 1'b0;
    drive(1'b0, OP_MFHI, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({stall, busy, rd_valid, mul_start, div_start} !== 5'b0) begin
      n_fail++; $display("FAIL reset_outputs: got stall/busy/rdv/ms/ds=%b want 00000",
                         {stall, busy, rd_valid, mul_start, div_start});
    end
    peek(OP_MFHI, v, vl);
    n_cmp++;
    if (vl !== 1'b1 || v !== 32'h0) begin
      n_fail++; $display("FAIL reset_hi: got v=%b d=%h want v=1 d=0", vl, v);
    end
    peek(OP_MFLO, v, vl);
    n_cmp++;
    if (vl !== 1'b1 || v !== 32'h0) begin
      n_fail++; $display("FAIL reset_lo: got v=%b d=%h want v=1 d=0", vl, v);
    end
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_mult_signed();
    logic [31:0] v;
    logic        vl;
    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3, OP_MFHI);
    peek(OP_MFHI, v, vl);
    n_cmp++;
    if (v !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL mult_neg_hi: got %h want ffffffff", v);
    end
    peek(OP_MFLO, v, vl);
    n_cmp++;
    if (v !== 32'hFFFF_FFFA) begin
      n_fail++; $display("FAIL mult_neg_lo: got %h want fffffffa", v);
    end
  endtask

  task automatic test_mul_zero();
    logic [31:0] v;
    logic        vl;
    run_op("multu_zero", OP_MULTU, 32'h0, 32'h1234_5678, OP_MFHI);
    peek(OP_MFLO, v, vl);
    n_cmp++;
    if (v !== 32'h0) begin
      n_fail++; $display("FAIL multu_zero_lo: got %h want 0", v);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    logic        vl;
    run_op("multu_7x6", OP_MULTU, 32'd7, 32'd6, OP_MFLO);
    peek(OP_MFLO, v, vl);
    n_cmp++;
    if (v !== 32'd42) begin
      n_fail++; $display("FAIL multu_7x6_lo: got %0d want 42", v);
    end
  endtask

  task automatic test_div();
    logic [31:0] v;
    logic        vl;
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, OP_MFLO);
    peek(OP_MFLO, v, vl);
    n_cmp++;
    if (v !== 32'd14) begin
      n_fail++; $display("FAIL divu_quot: got %0d want 14", v);
    end
    peek(OP_MFHI, v, vl);
    n_cmp++;
    if (v !== 32'd2) begin
      n_fail++; $display("FAIL divu_rem: got %0d want 2", v);
    end
    run_op("mthi_a5", OP_MTHI, 32'hA5, 32'h0, OP_MFHI);
    run_op("div_by_0", OP_DIV, 32'd1234, 32'h0, OP_MFHI);
    peek(OP_MFHI, v, vl);
    n_cmp++;
    if (v !== 32'hA5) begin
      n_fail++; $display("FAIL div0_hi: got %h want a5", v);
    end
    run_op("div_signed", OP_DIV, 32'hFFFF_FF9C, 32'd7, OP_MFHI);
  endtask

  task automatic test_flush();
    logic [31:0] v;
    logic        vl;
    run_op("pre_flush_mtlo", OP_MTLO, 32'h1357_9BDF, 32'h0, OP_MFLO);
    go();
    drive(1'b1, OP_MULT, 32'h0001_2345, 32'hFFFF_0003);
    for (int i = 1; i < 10; i++) begin
      go();
      drive(1'b0, OP_MFHI, 32'h0, 32'h0);
    end
    go();
    flush = 1'b1;
    drive(1'b1, OP_MTHI, 32'hDEAD_BEEF, 32'h0);
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL flush_cycle: got stall=%b busy=%b want stall=0 busy=1", stall, busy);
    end
    go();
    flush = 1'b0;
    drive(1'b1, OP_MFHI, 32'h0, 32'h0);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || rd_valid !== 1'b1 || rd_data !== m_hi) begin
      n_fail++; $display("FAIL flush_idle_hi: got busy=%b v=%b d=%h want busy=0 v=1 d=%h",
                         busy, rd_valid, rd_data, m_hi);
    end
    go();
    flush = 1'b1;
    drive(1'b1, OP_MFLO, 32'h0, 32'h0);
    @(negedge clk);
    n_cmp++;
    if (rd_valid !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL flush_ignores_req: got v=%b stall=%b want 0 0", rd_valid, stall);
    end
    go();
    flush = 1'b0;
    peek(OP_MFLO, v, vl);
    n_cmp++;
    if (v !== m_lo) begin
      n_fail++; $display("FAIL flush_lo_kept: got %h want %h", v, m_lo);
    end
    run_op("after_flush_2x3", OP_MULTU, 32'd2, 32'd3, OP_MFLO);
    peek(OP_MFLO, v, vl);
    n_cmp++;
    if (v !== 32'd6) begin
      n_fail++; $display("FAIL after_flush_lo: got %0d want 6", v);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] v;
    logic        vl;
    run_op("pre_rst_mthi", OP_MTHI, 32'h2468_ACE0, 32'h0, OP_MFHI);
    run_op("pre_rst_mtlo", OP_MTLO, 32'h1111_2222, 32'h0, OP_MFLO);
    go();
    drive(1'b1, OP_MULT, 32'h0000_0123, 32'h0000_0456);
    for (int i = 1; i < 20; i++) begin
      go();
      drive(1'b0, OP_MFHI, 32'h0, 32'h0);
    end
    go();
    rst = 1'b1;
    flush = 1'b1;
    drive(1'b1, OP_MTLO, 32'h7777_7777, 32'h0);
    go();
    rst = 1'b0;
    flush = 1'b0;
    drive(1'b1, OP_MFHI, 32'h0, 32'h0);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || rd_valid !== 1'b1 || rd_data !== 32'h0) begin
      n_fail++; $display("FAIL rst_midop_hi: got busy=%b v=%b d=%h want busy=0 v=1 d=0", busy, rd_valid, rd_data);
    end
    peek(OP_MFLO, v, vl);
    n_cmp++;
    if (v !== 32'h0) begin
      n_fail++; $display("FAIL rst_midop_lo: got %h want 0", v);
    end
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = rand_word();
      b = ($urandom_range(0, 5) == 0) ? 32'h0 : rand_word();
      run_op($sformatf("rand%0d_op%0d", i, o), o, a, b, ($urandom_range(0, 1) == 0) ? OP_MFHI : OP_MFLO);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    flush = 1'b0;
    drive(1'b0, OP_MFHI, 32'h0, 32'h0);
    test_reset();
    test_mult_signed();
    test_mul_zero();
    test_back_to_back();
    test_div();
    test_flush();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
